data_bus_slave: RTL

Data-side bus slave that sits directly downstream of the `cpu` data port and drives its `Data_BUS_READ` input. It consumes `ADDR`, `Data_BUS_WRITE`, `CS` and `WR_RD`, services accesses to an on-chip word RAM and to a small memory-mapped I/O window, and returns read data with a fixed one-cycle latency. The I/O window holds a GPIO output register, a cycle counter and a sticky bus-error flag.

---
 rtl/data_bus_pkg.sv | 24 ++
 rtl/data_bus_slave_if.sv | 27 ++
 rtl/data_ram.sv | 27 ++
 rtl/data_bus_slave.sv | 123 ++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_pkg
// Brief    : Shared constants and decode types for the data-side bus slave.
// Revision : 1.0
// ============================================================================
package data_bus_pkg;

  localparam logic [3:0]  IO_GPIO         = 4'h0;
  localparam logic [3:0]  IO_CYCLE        = 4'h4;
  localparam logic [3:0]  IO_STATUS       = 4'h8;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] UNMAPPED_RDATA  = 32'h0;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_GPIO,
    SEL_CYCLE,
    SEL_STATUS,
    SEL_UNMAPPED
  } target_sel_e;

endpackage
`default_nettype wire

// File: rtl/data_bus_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_slave_if
// Brief    : CPU data-port bus bundle between the CPU and the data slave.
// Revision : 1.0
// ============================================================================
interface data_bus_slave_if;

  logic [31:0] ADDR;
  logic [31:0] Data_BUS_WRITE;
  logic        CS;
  logic        WR_RD;
  logic [31:0] Data_BUS_READ;
  logic        RD_VALID;

  modport master (
    output ADDR, Data_BUS_WRITE, CS, WR_RD,
    input  Data_BUS_READ, RD_VALID
  );

  modport slave (
    input  ADDR, Data_BUS_WRITE, CS, WR_RD,
    output Data_BUS_READ, RD_VALID
  );

endinterface
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module   : data_ram
// Brief    : Single-port synchronous word RAM with registered read data.
// Revision : 1.0
// ============================================================================
module data_ram #(
  parameter int RAM_ADDR_W = 10
) (
  input  logic                  CLK_SYS,
  input  logic                  we,
  input  logic [RAM_ADDR_W-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] r_mem [2**RAM_ADDR_W];

  always_ff @(posedge CLK_SYS) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/data_bus_slave.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_slave
// Brief    : Data-side bus slave: word RAM plus GPIO/CYCLE/STATUS I/O window.
// Revision : 1.0
// ============================================================================
module data_bus_slave
  import data_bus_pkg::*;
#(
  parameter int          RAM_ADDR_W = 10,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic             CLK_SYS,
  input  logic             RST,
  data_bus_slave_if.slave  bus,
  output logic [31:0]      GPIO_OUT,
  output logic             BUS_ERR
);

  target_sel_e w_sel;
  logic        w_ram_hit;
  logic        w_io_hit;
  logic        w_wr;
  logic        w_rd;
  logic        w_ram_we;
  logic [31:0] w_io_rdata;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_bus_rdata;
  logic        w_unused_addr_lsbs;

  logic [31:0] r_gpio;
  logic [31:0] r_cycle;
  logic        r_bus_err;
  logic        r_rd_valid;
  logic        r_rd_from_ram;
  logic [31:0] r_rdata;

  assign w_unused_addr_lsbs = &{1'b0, bus.ADDR[1:0]};

  always_comb begin
    w_ram_hit = (bus.ADDR[31:RAM_ADDR_W+2] == '0);
    w_io_hit  = (bus.ADDR[31:4] == IO_BASE[31:4]);
    w_sel     = SEL_UNMAPPED;
    if (w_ram_hit) begin
      w_sel = SEL_RAM;
    end else if (w_io_hit) begin
      case ({bus.ADDR[3:2], 2'b00})
        IO_GPIO:   w_sel = SEL_GPIO;
        IO_CYCLE:  w_sel = SEL_CYCLE;
        IO_STATUS: w_sel = SEL_STATUS;
        default:   w_sel = SEL_UNMAPPED;
      endcase
    end
  end

  assign w_wr     = bus.CS &  bus.WR_RD;
  assign w_rd     = bus.CS & ~bus.WR_RD;
  // Gate with RST so an access coinciding with reset never reaches the array.
  assign w_ram_we = w_wr & (w_sel == SEL_RAM) & ~RST;

  always_comb begin
    w_io_rdata = UNMAPPED_RDATA;
    case (w_sel)
      SEL_GPIO:   w_io_rdata = r_gpio;
      SEL_CYCLE:  w_io_rdata = r_cycle;
      SEL_STATUS: w_io_rdata = {31'b0, r_bus_err};
      default:    w_io_rdata = UNMAPPED_RDATA;
    endcase
  end

  data_ram #(
    .RAM_ADDR_W (RAM_ADDR_W)
  ) u_data_ram (
    .CLK_SYS (CLK_SYS),
    .we      (w_ram_we),
    .addr    (bus.ADDR[RAM_ADDR_W+1:2]),
    .wdata   (bus.Data_BUS_WRITE),
    .rdata   (w_ram_rdata)
  );

  // RAM data is already registered inside the array, so it is forwarded for
  // the cycle after a RAM read and then frozen into r_rdata to hold.
  assign w_bus_rdata = r_rd_from_ram ? w_ram_rdata : r_rdata;

  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      r_gpio        <= '0;
      r_cycle       <= '0;
      r_bus_err     <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_from_ram <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_cycle <= (w_wr && (w_sel == SEL_CYCLE)) ? '0 : r_cycle + 32'd1;

      if (w_wr && (w_sel == SEL_GPIO)) begin
        r_gpio <= bus.Data_BUS_WRITE;
      end

      if (bus.CS && (w_sel == SEL_UNMAPPED)) begin
        r_bus_err <= 1'b1;
      end else if (w_wr && (w_sel == SEL_STATUS) && bus.Data_BUS_WRITE[0]) begin
        r_bus_err <= 1'b0;
      end

      r_rd_valid    <= w_rd;
      r_rd_from_ram <= w_rd && (w_sel == SEL_RAM);

      if (w_rd && (w_sel != SEL_RAM)) begin
        r_rdata <= w_io_rdata;
      end else if (r_rd_valid) begin
        r_rdata <= w_bus_rdata;
      end
    end
  end

  assign bus.Data_BUS_READ = w_bus_rdata;
  assign bus.RD_VALID      = r_rd_valid;
  assign GPIO_OUT          = r_gpio;
  assign BUS_ERR           = r_bus_err;

endmodule
`default_nettype wire
